tl_sink_downsizer: RTL and testbench
====================================

# tl_sink_downsizer

Adapter that narrows the TileLink Sink ID space between a device using DeviceSinkWidth-bit sinks and a host accepting only HostSinkWidth-bit sinks. It sits on the host side of a device, such as an L2 or directory. On each Grant/GrantData it allocates a compact sink slot and records the original device sink. It translates the matching GrantAck on E back to the original sink. Channels A, B and C pass through unchanged.

## Interface
- DataWidth, 64, data bus width in bits
- AddrWidth, 56, address width
- SourceWidth, 1, source ID width (unchanged across block)
- HostSinkWidth, 1, sink width on host-facing port; table has NumSlots = 2**HostSinkWidth entries
- DeviceSinkWidth, 3, sink width on device-facing port; must exceed HostSinkWidth (elaboration $fatal otherwise)
- MaxSize, 6, log2 of largest transfer in bytes
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- host_a/b/c/d/e_*  mixed  TL device port (DataWidth, AddrWidth, SourceWidth, HostSinkWidth)  toward host
- device_a/b/c/d/e_*  mixed  TL host port (DataWidth, AddrWidth, SourceWidth, DeviceSinkWidth)  toward device

## Operation
- A, B, C: all fields and valid/ready wired straight through.
- Grant detection: D beat with opcode Grant or GrantData. All other D opcodes pass through with host_d.sink = 0; they allocate nothing.
- Slot table state:
  - slot_valid_q[NumSlots], reset 0.
  - slot_sink_q[NumSlots][DeviceSinkWidth], no reset.
- Burst state:
  - in_burst_q, reset 0.
  - burst_slot_q[HostSinkWidth].
  - beats_left_q[MaxSize-log2(DataWidth/8)], reset 0.
- First beat of a Grant (in_burst_q = 0):
  - Allocation target is the lowest index i with slot_valid_q[i] = 0.
  - If no slot is free: host_d_valid = 0 and device_d_ready = 0. This stalls all D traffic, non-Grant beats included, to preserve ordering.
  - If a slot is free: host_d.sink = i. On the fire, slot_valid[i] <= 1 and slot_sink[i] <= device_d.sink.
- Multi-beat GrantData:
  - Beat count = 2**(size - log2(DataWidth/8)) when size exceeds the bus width, else 1.
  - On a first-beat fire with count > 1: in_burst_q <= 1, burst_slot_q <= i, beats_left_q <= count-1.
  - Later beats reuse burst_slot_q, never stall on table state, and decrement beats_left_q.
  - in_burst_q clears when the last beat fires.
- Non-Grant multi-beat D bursts (AccessAckData) are counted the same way so that beat boundaries stay correct. They never allocate.
- E channel:
  - device_e.sink = slot_sink_q[host_e.sink].
  - device_e_valid = host_e_valid and host_e_ready = device_e_ready.
  - On an E fire, slot_valid[host_e.sink] <= 0.
- Simultaneous E free and D allocation in one cycle: allocation uses slot_valid_q, so the slot being freed is not reusable until the next cycle. Both updates apply, and the free applies before the allocate in the next-state logic.
- Reset mid-burst: all slots invalid, in_burst_q = 0, beats_left_q = 0. Outstanding grants are lost, and the surrounding system must reset together.

## Timing
- Zero-cycle combinational data path on every channel; no added latency.
- Table and burst-state updates are visible the cycle after the handshake.
- While rst_i = 1, the following are forced to 0: host_d_valid, device_d_ready, device_e_valid, host_e_ready. A/B/C valid/ready still pass through.
- Handshakes: valid must not depend on ready on the same channel. The D stall depends only on registered state and device_d opcode/valid.
- Width rule: slot index is HostSinkWidth bits; device sinks are stored at full DeviceSinkWidth with no truncation.

## Configuration
- TL_SINK_DOWNSIZER_CHECK_EN defined: compiles in SVA checks, disabled during rst_i:
  - an E fire targets a slot with slot_valid_q = 1;
  - a Grant first beat never fires while all slots are valid;
  - beats_left_q never underflows.
- Undefined: no checks. An E to an invalid slot forwards the stale slot_sink_q and clears an already-clear bit.

## Test plan
- Single Grant, device sink 5, size 3: host sees sink 0. Host E sink 0 -> device_e.sink = 5, and slot 0 is free next cycle.
- GrantData, size 6, DataWidth 64 (8 beats), device sink 6: all 8 host beats carry sink 0. A second Grant arriving after this burst receives sink 1.
- Table full (HostSinkWidth 1, two outstanding grants, device sinks 2 and 7): a third Grant stalls with device_d_ready = 0. Issuing E sink 0 lets it pass next cycle with host sink 0, and E of that grant yields device_e.sink = that grant's device sink.
- Same-cycle E free of slot 1 and new Grant while slot 0 is free: the Grant takes slot 0. A follow-up Grant the next cycle takes slot 1.
- AccessAckData, 4 beats, interleaved with the table full: passes with no allocation, host sink 0, and no stall when in_burst.
- Assert rst_i mid GrantData burst (beat 3 of 8): the next cycle, slot_valid = 0, the burst is cleared, and host_d_valid = 0 while reset is held.

Source files
------------

// File: rtl/tl_sink_downsizer.sv
// tl_sink_downsizer: narrows the TileLink sink ID space from DeviceSinkWidth
// to HostSinkWidth bits. Each Grant/GrantData takes a compact slot that holds
// the device sink. The matching GrantAck on E is mapped back through that slot.
// Channels A, B and C pass straight through.
// Optional: define TL_SINK_DOWNSIZER_CHECK_EN to compile in protocol assertions.
module tl_sink_downsizer #(
  parameter int DataWidth       = 64,
  parameter int AddrWidth       = 56,
  parameter int SourceWidth     = 1,
  parameter int HostSinkWidth   = 1,
  parameter int DeviceSinkWidth = 3,
  parameter int MaxSize         = 6,
  localparam int SizeWidth      = $clog2(MaxSize + 1),
  localparam int MaskWidth      = DataWidth / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  // A: host -> device
  input  logic                       host_a_valid,
  output logic                       host_a_ready,
  input  logic [2:0]                 host_a_opcode,
  input  logic [2:0]                 host_a_param,
  input  logic [SizeWidth-1:0]       host_a_size,
  input  logic [SourceWidth-1:0]     host_a_source,
  input  logic [AddrWidth-1:0]       host_a_address,
  input  logic [MaskWidth-1:0]       host_a_mask,
  input  logic [DataWidth-1:0]       host_a_data,
  input  logic                       host_a_corrupt,
  output logic                       device_a_valid,
  input  logic                       device_a_ready,
  output logic [2:0]                 device_a_opcode,
  output logic [2:0]                 device_a_param,
  output logic [SizeWidth-1:0]       device_a_size,
  output logic [SourceWidth-1:0]     device_a_source,
  output logic [AddrWidth-1:0]       device_a_address,
  output logic [MaskWidth-1:0]       device_a_mask,
  output logic [DataWidth-1:0]       device_a_data,
  output logic                       device_a_corrupt,
  // B: device -> host
  input  logic                       device_b_valid,
  output logic                       device_b_ready,
  input  logic [2:0]                 device_b_opcode,
  input  logic [2:0]                 device_b_param,
  input  logic [SizeWidth-1:0]       device_b_size,
  input  logic [SourceWidth-1:0]     device_b_source,
  input  logic [AddrWidth-1:0]       device_b_address,
  input  logic [MaskWidth-1:0]       device_b_mask,
  input  logic [DataWidth-1:0]       device_b_data,
  input  logic                       device_b_corrupt,
  output logic                       host_b_valid,
  input  logic                       host_b_ready,
  output logic [2:0]                 host_b_opcode,
  output logic [2:0]                 host_b_param,
  output logic [SizeWidth-1:0]       host_b_size,
  output logic [SourceWidth-1:0]     host_b_source,
  output logic [AddrWidth-1:0]       host_b_address,
  output logic [MaskWidth-1:0]       host_b_mask,
  output logic [DataWidth-1:0]       host_b_data,
  output logic                       host_b_corrupt,
  // C: host -> device
  input  logic                       host_c_valid,
  output logic                       host_c_ready,
  input  logic [2:0]                 host_c_opcode,
  input  logic [2:0]                 host_c_param,
  input  logic [SizeWidth-1:0]       host_c_size,
  input  logic [SourceWidth-1:0]     host_c_source,
  input  logic [AddrWidth-1:0]       host_c_address,
  input  logic [DataWidth-1:0]       host_c_data,
  input  logic                       host_c_corrupt,
  output logic                       device_c_valid,
  input  logic                       device_c_ready,
  output logic [2:0]                 device_c_opcode,
  output logic [2:0]                 device_c_param,
  output logic [SizeWidth-1:0]       device_c_size,
  output logic [SourceWidth-1:0]     device_c_source,
  output logic [AddrWidth-1:0]       device_c_address,
  output logic [DataWidth-1:0]       device_c_data,
  output logic                       device_c_corrupt,
  // D: device -> host
  input  logic                       device_d_valid,
  output logic                       device_d_ready,
  input  logic [2:0]                 device_d_opcode,
  input  logic [1:0]                 device_d_param,
  input  logic [SizeWidth-1:0]       device_d_size,
  input  logic [SourceWidth-1:0]     device_d_source,
  input  logic [DeviceSinkWidth-1:0] device_d_sink,
  input  logic                       device_d_denied,
  input  logic [DataWidth-1:0]       device_d_data,
  input  logic                       device_d_corrupt,
  output logic                       host_d_valid,
  input  logic                       host_d_ready,
  output logic [2:0]                 host_d_opcode,
  output logic [1:0]                 host_d_param,
  output logic [SizeWidth-1:0]       host_d_size,
  output logic [SourceWidth-1:0]     host_d_source,
  output logic [HostSinkWidth-1:0]   host_d_sink,
  output logic                       host_d_denied,
  output logic [DataWidth-1:0]       host_d_data,
  output logic                       host_d_corrupt,
  // E: host -> device
  input  logic                       host_e_valid,
  output logic                       host_e_ready,
  input  logic [HostSinkWidth-1:0]   host_e_sink,
  output logic                       device_e_valid,
  input  logic                       device_e_ready,
  output logic [DeviceSinkWidth-1:0] device_e_sink
);

  localparam int NumSlots = 2 ** HostSinkWidth;
  localparam int LgBytes  = $clog2(DataWidth / 8);
  localparam int BeatW    = (MaxSize > LgBytes) ? (MaxSize - LgBytes) : 1;
  localparam logic [2:0] OpGrant     = 3'd4;
  localparam logic [2:0] OpGrantData = 3'd5;

  if (DeviceSinkWidth <= HostSinkWidth) begin : g_bad_widths
    $fatal(1, "tl_sink_downsizer: DeviceSinkWidth must exceed HostSinkWidth");
  end

  assign device_a_valid   = host_a_valid;
  assign host_a_ready     = device_a_ready;
  assign device_a_opcode  = host_a_opcode;
  assign device_a_param   = host_a_param;
  assign device_a_size    = host_a_size;
  assign device_a_source  = host_a_source;
  assign device_a_address = host_a_address;
  assign device_a_mask    = host_a_mask;
  assign device_a_data    = host_a_data;
  assign device_a_corrupt = host_a_corrupt;

  assign host_b_valid     = device_b_valid;
  assign device_b_ready   = host_b_ready;
  assign host_b_opcode    = device_b_opcode;
  assign host_b_param     = device_b_param;
  assign host_b_size      = device_b_size;
  assign host_b_source    = device_b_source;
  assign host_b_address   = device_b_address;
  assign host_b_mask      = device_b_mask;
  assign host_b_data      = device_b_data;
  assign host_b_corrupt   = device_b_corrupt;

  assign device_c_valid   = host_c_valid;
  assign host_c_ready     = device_c_ready;
  assign device_c_opcode  = host_c_opcode;
  assign device_c_param   = host_c_param;
  assign device_c_size    = host_c_size;
  assign device_c_source  = host_c_source;
  assign device_c_address = host_c_address;
  assign device_c_data    = host_c_data;
  assign device_c_corrupt = host_c_corrupt;

  assign host_d_opcode    = device_d_opcode;
  assign host_d_param     = device_d_param;
  assign host_d_size      = device_d_size;
  assign host_d_source    = device_d_source;
  assign host_d_denied    = device_d_denied;
  assign host_d_data      = device_d_data;
  assign host_d_corrupt   = device_d_corrupt;

  logic [NumSlots-1:0]        slot_valid_q, slot_valid_d;
  logic [DeviceSinkWidth-1:0] slot_sink_q [NumSlots];
  logic                       in_burst_q;
  logic [HostSinkWidth-1:0]   burst_slot_q;
  logic [BeatW-1:0]           beats_left_q;

  logic                       is_grant, free_found, stall, d_fire, e_fire, alloc;
  logic [HostSinkWidth-1:0]   free_idx;
  logic [BeatW-1:0]           first_left;

  // Lowest-index free slot, taken from registered state only.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = HostSinkWidth'(i);
      end
    end
  end

  // Beats remaining after the first beat of a message (opcode bit 0 marks data-bearing D messages).
  always_comb begin
    first_left = '0;
    if (device_d_opcode[0] && (int'(device_d_size) > LgBytes)) begin
      first_left = BeatW'((1 << (int'(device_d_size) - LgBytes)) - 1);
    end
  end

  // A Grant first beat with a full table holds the whole D channel so ordering is kept.
  assign is_grant       = (device_d_opcode == OpGrant) || (device_d_opcode == OpGrantData);
  assign stall          = !in_burst_q && is_grant && !free_found;
  assign host_d_valid   = device_d_valid && !stall && !rst_i;
  assign device_d_ready = host_d_ready && !stall && !rst_i;
  assign host_d_sink    = in_burst_q ? burst_slot_q : (is_grant ? free_idx : '0);
  assign d_fire         = device_d_valid && device_d_ready;
  assign alloc          = d_fire && !in_burst_q && is_grant;

  assign device_e_valid = host_e_valid && !rst_i;
  assign host_e_ready   = device_e_ready && !rst_i;
  assign device_e_sink  = slot_sink_q[host_e_sink];
  assign e_fire         = host_e_valid && host_e_ready;

  // Slot occupancy: the E free is applied first, then the new allocation.
  always_comb begin
    slot_valid_d = slot_valid_q;
    if (e_fire) slot_valid_d[host_e_sink] = 1'b0;
    if (alloc)  slot_valid_d[free_idx]    = 1'b1;
  end

  // Occupancy and burst tracking registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      slot_valid_q <= '0;
      in_burst_q   <= 1'b0;
      burst_slot_q <= '0;
      beats_left_q <= '0;
    end else begin
      slot_valid_q <= slot_valid_d;
      if (d_fire) begin
        if (!in_burst_q) begin
          if (first_left != '0) begin
            in_burst_q   <= 1'b1;
            beats_left_q <= first_left;
            burst_slot_q <= is_grant ? free_idx : '0;
          end
        end else begin
          beats_left_q <= beats_left_q - BeatW'(1);
          if (beats_left_q == BeatW'(1)) in_burst_q <= 1'b0;
        end
      end
    end
  end

  // Device sink capture; contents are only meaningful while the slot is valid.
  always_ff @(posedge clk_i) begin
    if (alloc) slot_sink_q[free_idx] <= device_d_sink;
  end

`ifdef TL_SINK_DOWNSIZER_CHECK_EN
  a_e_targets_valid: assert property (@(posedge clk_i) disable iff (rst_i)
    e_fire |-> slot_valid_q[host_e_sink]);
  a_no_grant_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(alloc && (&slot_valid_q)));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (d_fire && in_burst_q) |-> (beats_left_q != '0));
`else
  // Checks compiled out: an E to an empty slot forwards the stale device sink.
`endif

endmodule

// File: tb/tb_tl_sink_downsizer.sv
// Testbench for tl_sink_downsizer: directed scenarios plus randomized D/E traffic
// checked against a message-level model of the sink slot table.
module tb_tl_sink_downsizer;
  localparam int DW = 64, AW = 56, SW = 1, HSW = 1, DSW = 3, MS = 6, SZW = 3, MW = 8;
  localparam int NS = 2;

  logic clk_i = 1'b0, rst_i;
  logic host_a_valid, host_a_ready, host_a_corrupt, device_a_valid, device_a_ready, device_a_corrupt;
  logic [2:0] host_a_opcode, host_a_param, device_a_opcode, device_a_param;
  logic [SZW-1:0] host_a_size, device_a_size;
  logic [SW-1:0] host_a_source, device_a_source;
  logic [AW-1:0] host_a_address, device_a_address;
  logic [MW-1:0] host_a_mask, device_a_mask;
  logic [DW-1:0] host_a_data, device_a_data;
  logic device_b_valid, device_b_ready, device_b_corrupt, host_b_valid, host_b_ready, host_b_corrupt;
  logic [2:0] device_b_opcode, device_b_param, host_b_opcode, host_b_param;
  logic [SZW-1:0] device_b_size, host_b_size;
  logic [SW-1:0] device_b_source, host_b_source;
  logic [AW-1:0] device_b_address, host_b_address;
  logic [MW-1:0] device_b_mask, host_b_mask;
  logic [DW-1:0] device_b_data, host_b_data;
  logic host_c_valid, host_c_ready, host_c_corrupt, device_c_valid, device_c_ready, device_c_corrupt;
  logic [2:0] host_c_opcode, host_c_param, device_c_opcode, device_c_param;
  logic [SZW-1:0] host_c_size, device_c_size;
  logic [SW-1:0] host_c_source, device_c_source;
  logic [AW-1:0] host_c_address, device_c_address;
  logic [DW-1:0] host_c_data, device_c_data;
  logic device_d_valid, device_d_ready, device_d_denied, device_d_corrupt;
  logic host_d_valid, host_d_ready, host_d_denied, host_d_corrupt;
  logic [2:0] device_d_opcode, host_d_opcode;
  logic [1:0] device_d_param, host_d_param;
  logic [SZW-1:0] device_d_size, host_d_size;
  logic [SW-1:0] device_d_source, host_d_source;
  logic [DSW-1:0] device_d_sink;
  logic [HSW-1:0] host_d_sink;
  logic [DW-1:0] device_d_data, host_d_data;
  logic host_e_valid, host_e_ready, device_e_valid, device_e_ready;
  logic [HSW-1:0] host_e_sink;
  logic [DSW-1:0] device_e_sink;

  tl_sink_downsizer #(.DataWidth(DW), .AddrWidth(AW), .SourceWidth(SW), .HostSinkWidth(HSW),
                      .DeviceSinkWidth(DSW), .MaxSize(MS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a_opcode(host_a_opcode),
    .host_a_param(host_a_param), .host_a_size(host_a_size), .host_a_source(host_a_source),
    .host_a_address(host_a_address), .host_a_mask(host_a_mask), .host_a_data(host_a_data),
    .host_a_corrupt(host_a_corrupt),
    .device_a_valid(device_a_valid), .device_a_ready(device_a_ready), .device_a_opcode(device_a_opcode),
    .device_a_param(device_a_param), .device_a_size(device_a_size), .device_a_source(device_a_source),
    .device_a_address(device_a_address), .device_a_mask(device_a_mask), .device_a_data(device_a_data),
    .device_a_corrupt(device_a_corrupt),
    .device_b_valid(device_b_valid), .device_b_ready(device_b_ready), .device_b_opcode(device_b_opcode),
    .device_b_param(device_b_param), .device_b_size(device_b_size), .device_b_source(device_b_source),
    .device_b_address(device_b_address), .device_b_mask(device_b_mask), .device_b_data(device_b_data),
    .device_b_corrupt(device_b_corrupt),
    .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b_opcode(host_b_opcode),
    .host_b_param(host_b_param), .host_b_size(host_b_size), .host_b_source(host_b_source),
    .host_b_address(host_b_address), .host_b_mask(host_b_mask), .host_b_data(host_b_data),
    .host_b_corrupt(host_b_corrupt),
    .host_c_valid(host_c_valid), .host_c_ready(host_c_ready), .host_c_opcode(host_c_opcode),
    .host_c_param(host_c_param), .host_c_size(host_c_size), .host_c_source(host_c_source),
    .host_c_address(host_c_address), .host_c_data(host_c_data), .host_c_corrupt(host_c_corrupt),
    .device_c_valid(device_c_valid), .device_c_ready(device_c_ready), .device_c_opcode(device_c_opcode),
    .device_c_param(device_c_param), .device_c_size(device_c_size), .device_c_source(device_c_source),
    .device_c_address(device_c_address), .device_c_data(device_c_data), .device_c_corrupt(device_c_corrupt),
    .device_d_valid(device_d_valid), .device_d_ready(device_d_ready), .device_d_opcode(device_d_opcode),
    .device_d_param(device_d_param), .device_d_size(device_d_size), .device_d_source(device_d_source),
    .device_d_sink(device_d_sink), .device_d_denied(device_d_denied), .device_d_data(device_d_data),
    .device_d_corrupt(device_d_corrupt),
    .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d_opcode(host_d_opcode),
    .host_d_param(host_d_param), .host_d_size(host_d_size), .host_d_source(host_d_source),
    .host_d_sink(host_d_sink), .host_d_denied(host_d_denied), .host_d_data(host_d_data),
    .host_d_corrupt(host_d_corrupt),
    .host_e_valid(host_e_valid), .host_e_ready(host_e_ready), .host_e_sink(host_e_sink),
    .device_e_valid(device_e_valid), .device_e_ready(device_e_ready), .device_e_sink(device_e_sink)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0, errors = 0;

  // Message-level reference: which host slots hold a grant, and for which device sink,
  // plus how many beats of the current D message are still to come.
  bit m_valid [NS];
  int m_sink [NS];
  int m_left = 0, m_slot = 0;
  int p_free;
  bit p_first, p_grant, p_stall, p_dfire, p_efire;
  bit exp_hv, exp_dr;
  int exp_sink, exp_esink;

  task automatic predict();
    p_first = (m_left == 0);
    p_grant = (device_d_opcode == 3'd4) || (device_d_opcode == 3'd5);
    p_free = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_valid[i]) p_free = i;
    p_stall = p_first && p_grant && (p_free < 0);
    exp_hv = device_d_valid && !p_stall && !rst_i;
    exp_dr = host_d_ready && !p_stall && !rst_i;
    exp_sink = !p_first ? m_slot : (p_grant ? p_free : 0);
    exp_esink = m_sink[host_e_sink];
    p_dfire = device_d_valid && exp_dr;
    p_efire = host_e_valid && device_e_ready && !rst_i;
  endtask

  task automatic commit();
    int n;
    if (rst_i) begin
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      m_left = 0;
    end else begin
      if (p_efire) m_valid[host_e_sink] = 1'b0;
      if (p_dfire) begin
        if (p_first) begin
          n = (device_d_opcode[0] && int'(device_d_size) > 3) ? (1 << (int'(device_d_size) - 3)) : 1;
          if (p_grant) begin
            m_valid[p_free] = 1'b1;
            m_sink[p_free] = int'(device_d_sink);
          end
          m_left = n - 1;
          m_slot = p_grant ? p_free : 0;
        end else begin
          m_left--;
        end
      end
    end
  endtask

  task automatic tick();
    predict();
    @(posedge clk_i);
    commit();
    #1;
  endtask

  task automatic idle();
    device_d_valid = 1'b0; host_d_ready = 1'b1;
    host_e_valid = 1'b0; host_e_sink = '0; device_e_ready = 1'b1;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [SZW-1:0] sz, input logic [DSW-1:0] sk);
    device_d_valid = 1'b1; device_d_opcode = op; device_d_size = sz; device_d_sink = sk;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; drive_d(3'd4, 3'd3, 3'd1); host_e_valid = 1'b1;
    host_a_valid = 1'b1; device_a_ready = 1'b1;
    #2;
    vectors++; if (host_d_valid !== 1'b0) begin errors++; $display("FAIL reset_host_d_valid got %0b want 0", host_d_valid); end
    vectors++; if (device_d_ready !== 1'b0) begin errors++; $display("FAIL reset_device_d_ready got %0b want 0", device_d_ready); end
    vectors++; if (device_e_valid !== 1'b0) begin errors++; $display("FAIL reset_device_e_valid got %0b want 0", device_e_valid); end
    vectors++; if (host_e_ready !== 1'b0) begin errors++; $display("FAIL reset_host_e_ready got %0b want 0", host_e_ready); end
    vectors++; if (device_a_valid !== 1'b1 || host_a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_passthru got %0b/%0b want 1/1", device_a_valid, host_a_ready); end
    tick(); tick();
    rst_i = 1'b0; idle(); tick();
  endtask

  task automatic test_passthrough();
    for (int k = 0; k < 6; k++) begin
      host_a_address = AW'({$urandom, $urandom}); host_a_data = {$urandom, $urandom};
      host_a_mask = MW'($urandom); host_a_opcode = 3'($urandom);
      device_b_address = AW'({$urandom, $urandom}); device_b_source = SW'($urandom);
      host_c_data = {$urandom, $urandom}; host_c_opcode = 3'($urandom);
      device_d_data = {$urandom, $urandom};
      host_b_ready = 1'($urandom); device_c_ready = 1'($urandom);
      #2;
      vectors++; if (device_a_address !== host_a_address || device_a_data !== host_a_data || device_a_mask !== host_a_mask || device_a_opcode !== host_a_opcode)
        begin errors++; $display("FAIL pass_a got %h/%h want %h/%h", device_a_address, device_a_data, host_a_address, host_a_data); end
      vectors++; if (host_b_address !== device_b_address || host_b_source !== device_b_source || device_b_ready !== host_b_ready)
        begin errors++; $display("FAIL pass_b got %h want %h", host_b_address, device_b_address); end
      vectors++; if (device_c_data !== host_c_data || device_c_opcode !== host_c_opcode || host_c_ready !== device_c_ready)
        begin errors++; $display("FAIL pass_c got %h want %h", device_c_data, host_c_data); end
      vectors++; if (host_d_data !== device_d_data) begin errors++; $display("FAIL pass_d_data got %h want %h", host_d_data, device_d_data); end
      tick();
    end
  endtask

  task automatic test_single_grant();
    drive_d(3'd4, 3'd3, 3'd5); #2;
    vectors++; if (host_d_valid !== 1'b1 || host_d_sink !== 1'b0) begin errors++; $display("FAIL single_grant valid/sink got %0b/%0d want 1/0", host_d_valid, host_d_sink); end
    tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; #2;
    vectors++; if (device_e_valid !== 1'b1 || device_e_sink !== 3'd5) begin errors++; $display("FAIL single_e_sink got %0b/%0d want 1/5", device_e_valid, device_e_sink); end
    tick(); idle();
    drive_d(3'd4, 3'd3, 3'd1); #2;
    vectors++; if (host_d_sink !== 1'b0) begin errors++; $display("FAIL single_slot_reuse got %0d want 0", host_d_sink); end
    tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; tick(); idle(); tick();
  endtask

  task automatic test_grantdata_burst();
    drive_d(3'd5, 3'd6, 3'd6);
    for (int b = 0; b < 8; b++) begin
      if (b == 3) begin
        host_d_ready = 1'b0; #2;
        vectors++; if (device_d_ready !== 1'b0 || host_d_sink !== 1'b0) begin errors++; $display("FAIL burst_backpressure got %0b/%0d want 0/0", device_d_ready, host_d_sink); end
        tick(); host_d_ready = 1'b1;
      end
      #2;
      vectors++; if (host_d_valid !== 1'b1 || host_d_sink !== 1'b0) begin errors++; $display("FAIL burst_beat%0d got %0b/%0d want 1/0", b, host_d_valid, host_d_sink); end
      tick();
    end
    drive_d(3'd4, 3'd0, 3'd1); #2;
    vectors++; if (host_d_sink !== 1'b1) begin errors++; $display("FAIL burst_next_grant got %0d want 1", host_d_sink); end
    tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; #2;
    vectors++; if (device_e_sink !== 3'd6) begin errors++; $display("FAIL burst_e0 got %0d want 6", device_e_sink); end
    tick(); host_e_sink = 1'b1; #2;
    vectors++; if (device_e_sink !== 3'd1) begin errors++; $display("FAIL burst_e1 got %0d want 1", device_e_sink); end
    tick(); idle(); tick();
  endtask

  task automatic test_table_full();
    drive_d(3'd4, 3'd3, 3'd2); tick();
    drive_d(3'd4, 3'd3, 3'd7); tick();
    drive_d(3'd4, 3'd3, 3'd4); #2;
    vectors++; if (device_d_ready !== 1'b0 || host_d_valid !== 1'b0) begin errors++; $display("FAIL full_stall got %0b/%0b want 0/0", device_d_ready, host_d_valid); end
    tick();
    host_e_valid = 1'b1; host_e_sink = 1'b0; #2;
    vectors++; if (device_d_ready !== 1'b0 || device_e_sink !== 3'd2) begin errors++; $display("FAIL full_free_cycle got %0b/%0d want 0/2", device_d_ready, device_e_sink); end
    tick(); host_e_valid = 1'b0; #2;
    vectors++; if (host_d_valid !== 1'b1 || device_d_ready !== 1'b1 || host_d_sink !== 1'b0) begin errors++; $display("FAIL full_release got %0b/%0b/%0d want 1/1/0", host_d_valid, device_d_ready, host_d_sink); end
    tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; #2;
    vectors++; if (device_e_sink !== 3'd4) begin errors++; $display("FAIL full_third_e got %0d want 4", device_e_sink); end
    tick(); host_e_sink = 1'b1; #2;
    vectors++; if (device_e_sink !== 3'd7) begin errors++; $display("FAIL full_second_e got %0d want 7", device_e_sink); end
    tick(); idle(); tick();
  endtask

  task automatic test_same_cycle();
    drive_d(3'd4, 3'd0, 3'd1); tick();
    drive_d(3'd4, 3'd0, 3'd3); tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b1; drive_d(3'd4, 3'd0, 3'd5); #2;
    vectors++; if (host_d_sink !== 1'b0 || device_e_sink !== 3'd3) begin errors++; $display("FAIL same_cycle got %0d/%0d want 0/3", host_d_sink, device_e_sink); end
    tick(); host_e_valid = 1'b0; drive_d(3'd4, 3'd0, 3'd6); #2;
    vectors++; if (host_d_sink !== 1'b1 || host_d_valid !== 1'b1) begin errors++; $display("FAIL same_cycle_next got %0d/%0b want 1/1", host_d_sink, host_d_valid); end
    tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; #2;
    vectors++; if (device_e_sink !== 3'd5) begin errors++; $display("FAIL same_cycle_e0 got %0d want 5", device_e_sink); end
    tick(); host_e_sink = 1'b1; tick(); idle(); tick();
  endtask

  task automatic test_accessackdata();
    drive_d(3'd4, 3'd3, 3'd2); tick();
    drive_d(3'd5, 3'd4, 3'd7); tick();
    #2;
    vectors++; if (host_d_valid !== 1'b1 || host_d_sink !== 1'b1) begin errors++; $display("FAIL gd_tail_full got %0b/%0d want 1/1", host_d_valid, host_d_sink); end
    tick();
    drive_d(3'd1, 3'd5, 3'd0);
    for (int b = 0; b < 4; b++) begin
      #2;
      vectors++; if (host_d_valid !== 1'b1 || host_d_sink !== 1'b0) begin errors++; $display("FAIL aad_beat%0d got %0b/%0d want 1/0", b, host_d_valid, host_d_sink); end
      tick();
    end
    drive_d(3'd4, 3'd3, 3'd3); #2;
    vectors++; if (device_d_ready !== 1'b0) begin errors++; $display("FAIL aad_then_stall got %0b want 0", device_d_ready); end
    tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; #2;
    vectors++; if (device_e_sink !== 3'd2) begin errors++; $display("FAIL aad_e0 got %0d want 2", device_e_sink); end
    tick(); host_e_sink = 1'b1; tick(); idle(); tick();
  endtask

  task automatic test_reset_midburst();
    drive_d(3'd5, 3'd6, 3'd6);
    for (int b = 0; b < 3; b++) tick();
    rst_i = 1'b1; #2;
    vectors++; if (host_d_valid !== 1'b0 || device_d_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_hold got %0b/%0b want 0/0", host_d_valid, device_d_ready); end
    tick(); #2;
    vectors++; if (host_d_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_hold2 got %0b want 0", host_d_valid); end
    tick();
    rst_i = 1'b0; drive_d(3'd4, 3'd3, 3'd3); #2;
    vectors++; if (host_d_valid !== 1'b1 || host_d_sink !== 1'b0) begin errors++; $display("FAIL rst_mid_after got %0b/%0d want 1/0", host_d_valid, host_d_sink); end
    tick(); drive_d(3'd4, 3'd3, 3'd4); #2;
    vectors++; if (host_d_sink !== 1'b1) begin errors++; $display("FAIL rst_mid_second got %0d want 1", host_d_sink); end
    tick(); idle();
    host_e_valid = 1'b1; host_e_sink = 1'b0; #2;
    vectors++; if (device_e_sink !== 3'd3) begin errors++; $display("FAIL rst_mid_e0 got %0d want 3", device_e_sink); end
    tick(); host_e_sink = 1'b1; tick(); idle(); tick();
  endtask

  task automatic test_random();
    logic [2:0] ops [4];
    int s;
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4; ops[3] = 3'd5;
    for (int c = 0; c < 600; c++) begin
      rst_i = ($urandom_range(0, 149) == 0);
      if (m_left == 0) begin
        device_d_opcode = ops[$urandom_range(0, 3)];
        device_d_size = 3'($urandom_range(0, 6));
        device_d_sink = 3'($urandom);
      end
      device_d_valid = ($urandom_range(0, 3) != 0);
      host_d_ready = ($urandom_range(0, 3) != 0);
      s = $urandom_range(0, NS - 1);
      host_e_sink = 1'(s);
      host_e_valid = m_valid[s] && ($urandom_range(0, 2) == 0);
      device_e_ready = 1'($urandom);
      #2; predict();
      vectors++; if (host_d_valid !== exp_hv) begin errors++; $display("FAIL rand_hv c=%0d got %0b want %0b", c, host_d_valid, exp_hv); end
      vectors++; if (device_d_ready !== exp_dr) begin errors++; $display("FAIL rand_dr c=%0d got %0b want %0b", c, device_d_ready, exp_dr); end
      if (exp_hv) begin
        vectors++; if (int'(host_d_sink) !== exp_sink) begin errors++; $display("FAIL rand_sink c=%0d got %0d want %0d", c, host_d_sink, exp_sink); end
      end
      if (host_e_valid && !rst_i) begin
        vectors++; if (int'(device_e_sink) !== exp_esink) begin errors++; $display("FAIL rand_esink c=%0d got %0d want %0d", c, device_e_sink, exp_esink); end
      end
      tick();
    end
    rst_i = 1'b0; idle(); tick();
  endtask

  initial begin
    rst_i = 1'b1; idle();
    device_d_opcode = '0; device_d_param = '0; device_d_size = '0; device_d_source = '0;
    device_d_sink = '0; device_d_denied = 1'b0; device_d_data = '0; device_d_corrupt = 1'b0;
    host_a_valid = 1'b0; host_a_opcode = '0; host_a_param = '0; host_a_size = '0; host_a_source = '0;
    host_a_address = '0; host_a_mask = '0; host_a_data = '0; host_a_corrupt = 1'b0; device_a_ready = 1'b0;
    device_b_valid = 1'b0; device_b_opcode = '0; device_b_param = '0; device_b_size = '0; device_b_source = '0;
    device_b_address = '0; device_b_mask = '0; device_b_data = '0; device_b_corrupt = 1'b0; host_b_ready = 1'b0;
    host_c_valid = 1'b0; host_c_opcode = '0; host_c_param = '0; host_c_size = '0; host_c_source = '0;
    host_c_address = '0; host_c_data = '0; host_c_corrupt = 1'b0; device_c_ready = 1'b0;
    for (int i = 0; i < NS; i++) begin m_valid[i] = 1'b0; m_sink[i] = 0; end
    #1;
    tick(); tick();
    test_reset();
    test_passthrough();
    test_single_grant();
    test_grantdata_burst();
    test_table_full();
    test_same_cycle();
    test_accessackdata();
    test_reset_midburst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
